empty_ptr_pool: RTL
===================

EMPTY_PTR_POOL -- requirements
Module: empty_ptr_pool

Interface
REQ-001 Parameter A_WIDTH, default 8, pointer width; pool size DEPTH = 2**A_WIDTH.
REQ-002 Parameter INIT_FILL, default 1: 1 = pool auto-filled with every pointer after reset; 0 = pool starts empty.
REQ-003 clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 srst_i  input  1  synchronous, active-high reset; same effect as rst_i at the next edge.
REQ-006 add_empty_ptr_i  input  A_WIDTH  pointer being returned (freed).
REQ-007 add_empty_ptr_en_i  input  1  free strobe, one pointer per cycle.
REQ-008 next_empty_ptr_rd_ack_i  input  1  consumer takes next_empty_ptr_o this cycle.
REQ-009 next_empty_ptr_o  output  A_WIDTH  head pointer, show-ahead.
REQ-010 next_empty_ptr_val_o  output  1  head pointer valid.
REQ-011 free_cnt_o  output  A_WIDTH+1  number of pointers held in the pool.
REQ-012 init_done_o  output  1  high once the initial fill is complete.
REQ-013 err_double_free_o  output  1  one-cycle pulse: free was rejected.
REQ-014 err_underflow_o  output  1  one-cycle pulse: ack with val low.

Function
REQ-015 Storage: DEPTH-entry circular FIFO (write/read pointers A_WIDTH bits, natural wrap) plus a DEPTH-bit ownership bitmap, 1 = allocated.
REQ-016 FSM states: INIT, READY. Reset enters INIT if INIT_FILL=1, otherwise READY.
REQ-017 INIT: a counter pushes 0,1,...,DEPTH-1 into the FIFO, one per cycle, DEPTH cycles total; bitmap all 0; after value DEPTH-1 is written, go to READY.
REQ-018 INIT_FILL=0: bitmap resets to all 1; FIFO empty; init_done_o is 1 from the first cycle after reset.
REQ-019 In INIT: init_done_o=0, next_empty_ptr_val_o=0; frees and acks are ignored; ack raises err_underflow_o; free raises err_double_free_o.
REQ-020 next_empty_ptr_val_o = READY and FIFO not empty; next_empty_ptr_o is the FIFO head, stable while val is high and no ack is given.
REQ-021 Ack with val=1: pop head and set its bitmap bit to 1; the new head or val=0 is visible the next cycle.
REQ-022 Ack with val=0: no state change; err_underflow_o=1 for that cycle.
REQ-023 Free with bitmap bit=1: push the pointer, clear its bit, and raise next_empty_ptr_val_o one cycle later if the FIFO was empty (no same-cycle bypass).
REQ-024 Free with bitmap bit=0 (double free): pointer dropped, nothing changes; err_double_free_o=1 for that cycle.
REQ-025 Bitmap checks use the pre-edge bitmap; freeing the pointer being acked in the same cycle counts as a double free.
REQ-026 Simultaneous valid free and valid ack: both performed; free_cnt_o unchanged.
REQ-027 free_cnt_o: +1 on an accepted free or INIT push, -1 on a valid ack, registered, range 0..DEPTH.
REQ-028 FIFO overflow is structurally impossible (the bitmap limits the pool to DEPTH entries); no full output.

Reset
REQ-029 rst_i (async) and srst_i (sync): FIFO pointers=0, free_cnt_o=0, next_empty_ptr_val_o=0, error pulses=0, init counter=0, FSM to its reset state.
REQ-030 Bitmap: all 0 if INIT_FILL=1, all 1 if INIT_FILL=0.
REQ-031 next_empty_ptr_o = 0 during reset.
REQ-032 Reset mid-INIT or mid-traffic aborts all activity; INIT restarts from pointer 0 and prior allocations are forgotten.

Verification
REQ-033 A_WIDTH=3, INIT_FILL=1, reset release -> init_done_o rises after 8 cycles; free_cnt_o=8; acks return 0..7 in order; then val=0 and free_cnt_o=0.
REQ-034 After draining, free 5 -> val high next cycle with ptr 5; free 5 again -> err_double_free_o pulse; free_cnt_o stays 1.
REQ-035 Pool holding {2,3}: ack and free 6 in the same cycle -> 2 is popped, 6 is accepted; free_cnt_o stays 2; next heads are 3 then 6.
REQ-036 Ack while val=0, and ack or free during INIT -> err_underflow_o / err_double_free_o pulse; free_cnt_o and the FIFO are unchanged.
REQ-037 INIT_FILL=0: free 0..7, ack 8 times -> order 0..7; write/read pointers wrap correctly over 3 full rounds.
REQ-038 Assert srst_i at INIT cycle 4, and separately pulse rst_i asynchronously mid-traffic -> outputs match REQ-029; INIT restarts and delivers 0..7.

Source files
------------

// File: rtl/empty_ptr_pool.sv
// Free-pointer pool: circular FIFO of unused pointers plus an ownership bitmap that
// rejects double frees. It can optionally self-fill with every pointer after reset.
module empty_ptr_pool #(
  parameter int A_WIDTH   = 8,
  parameter bit INIT_FILL = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               srst_i,
  input  logic [A_WIDTH-1:0] add_empty_ptr_i,
  input  logic               add_empty_ptr_en_i,
  input  logic               next_empty_ptr_rd_ack_i,
  output logic [A_WIDTH-1:0] next_empty_ptr_o,
  output logic               next_empty_ptr_val_o,
  output logic [A_WIDTH:0]   free_cnt_o,
  output logic               init_done_o,
  output logic               err_double_free_o,
  output logic               err_underflow_o
);

  localparam int DEPTH = 2**A_WIDTH;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  localparam state_e           RST_STATE  = INIT_FILL ? ST_INIT : ST_READY;
  localparam logic [DEPTH-1:0] RST_BITMAP = {DEPTH{~INIT_FILL}};

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [A_WIDTH:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]   bitmap_q, bitmap_d;
  logic [A_WIDTH-1:0] mem_q [DEPTH];

  logic               val;
  logic [A_WIDTH-1:0] head;
  logic               ack_ok;
  logic               free_ok;
  logic               mem_we;
  logic [A_WIDTH-1:0] mem_wdata;

  assign val     = (state_q == ST_READY) && (cnt_q != '0);
  assign head    = mem_q[rd_ptr_q];
  assign ack_ok  = next_empty_ptr_rd_ack_i && val;
  // Bitmap is sampled pre-edge, so freeing the pointer being acked is a double free.
  assign free_ok = (state_q == ST_READY) && add_empty_ptr_en_i && bitmap_q[add_empty_ptr_i];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    init_cnt_d = init_cnt_q;
    cnt_d      = cnt_q;
    bitmap_d   = bitmap_q;
    mem_we     = 1'b0;
    mem_wdata  = add_empty_ptr_i;
    case (state_q)
      ST_INIT: begin
        mem_we     = 1'b1;
        mem_wdata  = init_cnt_q;
        wr_ptr_d   = wr_ptr_q + 1'b1;
        cnt_d      = cnt_q + 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == A_WIDTH'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      default: begin
        if (ack_ok) begin
          rd_ptr_d       = rd_ptr_q + 1'b1;
          bitmap_d[head] = 1'b1;
        end
        if (free_ok) begin
          mem_we                    = 1'b1;
          wr_ptr_d                  = wr_ptr_q + 1'b1;
          bitmap_d[add_empty_ptr_i] = 1'b0;
        end
        cnt_d = cnt_q + (A_WIDTH+1)'(free_ok) - (A_WIDTH+1)'(ack_ok);
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RST_STATE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      init_cnt_q <= '0;
      cnt_q      <= '0;
      bitmap_q   <= RST_BITMAP;
    end else if (srst_i) begin
      state_q    <= RST_STATE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      init_cnt_q <= '0;
      cnt_q      <= '0;
      bitmap_q   <= RST_BITMAP;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      init_cnt_q <= init_cnt_d;
      cnt_q      <= cnt_d;
      bitmap_q   <= bitmap_d;
    end
  end

  // Pointer storage carries no reset; stale entries are never visible because val gates the head.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= mem_wdata;
    end
  end

  assign next_empty_ptr_o     = val ? head : '0;
  assign next_empty_ptr_val_o = val;
  assign free_cnt_o           = cnt_q;
  assign init_done_o          = (state_q == ST_READY);
  assign err_underflow_o      = next_empty_ptr_rd_ack_i && !val && !rst_i && !srst_i;
  assign err_double_free_o    = add_empty_ptr_en_i && !free_ok && !rst_i && !srst_i;

endmodule
